// File: rtl/jump_motion.sv
// jump_motion: latches a jump length and animates one jump over 2**FLIGHT_LOG2 ticks.
// Define JUMP_LAND_HOLD_EN to add a LAND state that holds busy for LAND_TICKS ticks.
module jump_motion #(
    parameter int FLIGHT_LOG2 = 5,
    parameter int H_SHIFT     = 2,
    parameter int MAX_LEN     = 800
`ifdef JUMP_LAND_HOLD_EN
   ,parameter int LAND_TICKS  = 8
`endif
) (
    input  logic       clk,
    input  logic       clean_n,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] length,
    output logic       busy,
    output logic       done,
    output logic [9:0] jump_x,
    output logic [9:0] jump_y
);

    localparam int T  = 1 << FLIGHT_LOG2;
    localparam int TW = FLIGHT_LOG2 + 1;
    localparam int AW = 10 + FLIGHT_LOG2;

`ifdef JUMP_LAND_HOLD_EN
    localparam int LW = $clog2(LAND_TICKS + 1);
    typedef enum logic [1:0] {IDLE, FLY, LAND} state_t;
    logic [LW-1:0] lcnt_q, lcnt_d;
`else
    typedef enum logic {IDLE, FLY} state_t;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [9:0]      len_q, len_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [TW-1:0]   t_inc;
    logic [TW-1:0]   t_rem;
    logic [2*TW-1:0] prod;
    logic [AW-1:0]   acc_sum;

    // Next-state and next-output computation for the jump sequencer
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        acc_d   = acc_q;
        len_d   = len_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef JUMP_LAND_HOLD_EN
        lcnt_d  = lcnt_q;
`endif
        t_inc   = t_q + TW'(1);
        t_rem   = TW'(T) - t_inc;
        prod    = {{TW{1'b0}}, t_inc} * {{TW{1'b0}}, t_rem};
        acc_sum = acc_q + AW'(len_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = (length > 10'(MAX_LEN)) ? 10'(MAX_LEN) : length;
                    t_d     = '0;
                    acc_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b1;
                    state_d = FLY;
                end
            end
            FLY: begin
                if (tick) begin
                    t_d   = t_inc;
                    acc_d = acc_sum;
                    x_d   = 10'(acc_sum >> FLIGHT_LOG2);
                    y_d   = 10'(prod >> H_SHIFT);
                    if (t_inc == TW'(T)) begin
                        x_d = len_q;
                        y_d = '0;
`ifdef JUMP_LAND_HOLD_EN
                        lcnt_d  = '0;
                        state_d = LAND;
`else
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef JUMP_LAND_HOLD_EN
            LAND: begin
                if (tick) begin
                    lcnt_d = lcnt_q + LW'(1);
                    if (lcnt_d == LW'(LAND_TICKS)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; synchronous reset wins over everything
    always_ff @(posedge clk) begin
        if (!clean_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            acc_q   <= '0;
            len_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef JUMP_LAND_HOLD_EN
            lcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef JUMP_LAND_HOLD_EN
            lcnt_q  <= lcnt_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign jump_x = x_q;
    assign jump_y = y_q;

endmodule

// File: tb/tb_jump_motion.sv
// tb_jump_motion: randomized self-checking bench for jump_motion.
// Expected trajectory comes from closed-form position/height formulas.
module tb_jump_motion;

    localparam int F    = 5;
    localparam int T    = 1 << F;
    localparam int HS   = 2;
    localparam int MAXL = 800;
`ifdef JUMP_LAND_HOLD_EN
    localparam int LANDN = 8;
`else
    localparam int LANDN = 0;
`endif

    logic       clk     = 1'b0;
    logic       clean_n = 1'b0;
    logic       tick    = 1'b0;
    logic       start   = 1'b0;
    logic [9:0] length  = '0;
    logic       busy;
    logic       done;
    logic [9:0] jump_x;
    logic [9:0] jump_y;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    jump_motion dut (
        .clk     (clk),
        .clean_n (clean_n),
        .tick    (tick),
        .start   (start),
        .length  (length),
        .busy    (busy),
        .done    (done),
        .jump_x  (jump_x),
        .jump_y  (jump_y)
    );

    // Expected {busy,done,x,y} after n flight ticks of a jump of length L.
    // gap=1 means a non-tick cycle after tick n, so no done pulse is present.
    function automatic logic [21:0] model(input int L, input int n, input bit gap);
        logic b;
        logic d;
        int   x;
        int   y;
        if (n < T) begin
            b = 1'b1;
            d = 1'b0;
            x = (n * L) / T;
            y = (n * (T - n)) / (1 << HS);
        end else begin
            b = (n < T + LANDN);
            d = (n == T + LANDN) && !gap;
            x = L;
            y = 0;
        end
        return {b, d, 10'(x), 10'(y)};
    endfunction

    task automatic drive(input logic tk, input logic st, input logic [9:0] ln);
        @(negedge clk);
        tick   = tk;
        start  = st;
        length = ln;
        @(posedge clk);
        #1;
    endtask

    task automatic test_flight(input string nm, input int req,
                               input int restart_at, input int abort_at);
        int          L;
        int          dones;
        int          gap;
        logic [21:0] exp;
        L     = (req > MAXL) ? MAXL : req;
        dones = 0;
        drive(1'b1, 1'b1, 10'(req));
        exp = {1'b1, 1'b0, 10'd0, 10'd0};
        total_cnt++;
        if ({busy, done, jump_x, jump_y} !== exp)
            $display("FAIL %s/start got b=%0b d=%0b x=%0d y=%0d want b=%0b d=%0b x=%0d y=%0d",
                     nm, busy, done, jump_x, jump_y, exp[21], exp[20], exp[19:10], exp[9:0]);
        else
            pass_cnt++;
        for (int n = 1; n <= T + LANDN; n++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) begin
                    drive(1'b0, 1'($urandom_range(0, 1)), 10'($urandom));
                    dones += int'(done);
                end
                exp = model(L, n - 1, 1'b1);
                total_cnt++;
                if ({busy, done, jump_x, jump_y} !== exp)
                    $display("FAIL %s/hold n=%0d got b=%0b d=%0b x=%0d y=%0d want b=%0b d=%0b x=%0d y=%0d",
                             nm, n - 1, busy, done, jump_x, jump_y,
                             exp[21], exp[20], exp[19:10], exp[9:0]);
                else
                    pass_cnt++;
            end
            if (n == restart_at) drive(1'b1, 1'b1, 10'd100);
            else drive(1'b1, 1'b0, 10'($urandom));
            dones += int'(done);
            exp = model(L, n, 1'b0);
            total_cnt++;
            if ({busy, done, jump_x, jump_y} !== exp)
                $display("FAIL %s/tick n=%0d got b=%0b d=%0b x=%0d y=%0d want b=%0b d=%0b x=%0d y=%0d",
                         nm, n, busy, done, jump_x, jump_y,
                         exp[21], exp[20], exp[19:10], exp[9:0]);
            else
                pass_cnt++;
            if (n == abort_at) begin
                clean_n = 1'b0;
                drive(1'b1, 1'b1, 10'($urandom));
                clean_n = 1'b1;
                total_cnt++;
                if ({busy, done, jump_x, jump_y} !== 22'd0)
                    $display("FAIL %s/abort got b=%0b d=%0b x=%0d y=%0d want all 0",
                             nm, busy, done, jump_x, jump_y);
                else
                    pass_cnt++;
                drive(1'b0, 1'b0, 10'd0);
                dones += int'(done);
                total_cnt++;
                if (dones !== 0)
                    $display("FAIL %s/abort_done got %0d pulses want 0", nm, dones);
                else
                    pass_cnt++;
                return;
            end
        end
        drive(1'b1, 1'b0, 10'($urandom));
        dones += int'(done);
        exp = model(L, T + LANDN, 1'b1);
        total_cnt++;
        if ({busy, done, jump_x, jump_y} !== exp)
            $display("FAIL %s/idle got b=%0b d=%0b x=%0d y=%0d want b=%0b d=%0b x=%0d y=%0d",
                     nm, busy, done, jump_x, jump_y, exp[21], exp[20], exp[19:10], exp[9:0]);
        else
            pass_cnt++;
        total_cnt++;
        if (dones !== 1)
            $display("FAIL %s/done_count got %0d want 1", nm, dones);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        clean_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom));
            total_cnt++;
            if ({busy, done, jump_x, jump_y} !== 22'd0)
                $display("FAIL reset%0d got b=%0b d=%0b x=%0d y=%0d want all 0",
                         i, busy, done, jump_x, jump_y);
            else
                pass_cnt++;
        end
        clean_n = 1'b1;
        drive(1'b1, 1'b0, 10'($urandom));
        total_cnt++;
        if ({busy, done, jump_x, jump_y} !== 22'd0)
            $display("FAIL reset_idle got b=%0b d=%0b x=%0d y=%0d want all 0",
                     busy, done, jump_x, jump_y);
        else
            pass_cnt++;
    endtask

    task automatic test_nominal();
        test_flight("nominal", 320, 0, 0);
    endtask

    task automatic test_clamp();
        test_flight("clamp", 1000, 0, 0);
    endtask

    task automatic test_ignore_start();
        test_flight("ignore_start", 200, 5, 0);
    endtask

    task automatic test_abort();
        test_flight("abort", 320, 0, 10);
        test_flight("after_abort", 64, 0, 0);
    endtask

    task automatic test_zero_len();
        test_flight("zero_len", 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            test_flight($sformatf("random%0d", i), $urandom_range(0, 1023),
                        $urandom_range(1, T + LANDN), 0);
    endtask

`ifdef JUMP_LAND_HOLD_EN
    task automatic test_land_hold();
        test_flight("land_hold", 320, 35, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_clamp();
        test_ignore_start();
        test_abort();
        test_zero_len();
        test_back_to_back();
`ifdef JUMP_LAND_HOLD_EN
        test_land_hold();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
